// File: rtl/shift_add_mult_ctrl_if.sv
// shift_add_mult_ctrl_if: start/busy/done handshake bundle (start, a, b in; busy, done, p out)
interface shift_add_mult_ctrl_if #(parameter int N = 4);
  logic start;
  logic [N-1:0] a, b;
  logic busy, done;
  logic [2*N-1:0] p;
  modport master(output start, a, b, input busy, done, p);
  modport slave(input start, a, b, output busy, done, p);
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: sequential shift-and-add unsigned multiplier sharing one N-bit adder
// Ports: clk, rst_n (async active-low), bus.slave {start, a, b -> busy, done, p[2N-1:0]}
// Option: define MULT_ZERO_SKIP_EN to finish zero-operand products straight from IDLE
module adder #(parameter int N = 4) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N:0]   s
);
  assign s = {1'b0, x} + {1'b0, y};
endmodule

module shift_add_mult_ctrl #(parameter int N = 4) (
  input logic clk,
  input logic rst_n,
  shift_add_mult_ctrl_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [N-1:0] mcand;
  logic [2*N-1:0] acc, acc_sh, p;
  logic [CW-1:0] cnt;
  logic [N:0] s;
  logic last, skip;
`ifdef MULT_ZERO_SKIP_EN
  assign skip = bus.a == '0 || bus.b == '0;
`else
  assign skip = 1'b0;
`endif
  adder #(.N(N)) u_adder (.x(acc[2*N-1:N]), .y(acc[0] ? mcand : '0), .s(s));
  // carry of the partial sum enters the MSB as the accumulator shifts right
  assign acc_sh = {s, acc[N-1:1]};
  assign last = cnt == CW'(N - 1);
  always_comb
    state_nx = state == IDLE ? (bus.start ? (skip ? DONE : RUN) : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand <= '0;
      acc <= '0;
      cnt <= '0;
      p <= '0;
    end else if (state == IDLE && bus.start) begin
      mcand <= bus.a;
      acc <= {{N{1'b0}}, bus.b};
      cnt <= '0;
      if (skip) p <= '0;
    end else if (state == RUN) begin
      acc <= acc_sh;
      cnt <= cnt + CW'(1);
      if (last) p <= acc_sh;
    end
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.p = p;
endmodule
